// File: rtl/feature_unloader.sv
// Captures a full element vector on load and streams it out as address-tagged
// wide words over valid/ready, using the same slot packing as the feature loader.
module feature_unloader #(
  parameter int outputWidth  = 256,
  parameter int addrWidth    = 8,
  parameter int elementWidth = 8,
  parameter int numElements  = 128
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [numElements*elementWidth-1:0] data_i,
  input  logic                                load_i,
  output logic                                load_ready_o,
  input  logic [15:0]                         mask_start,
  input  logic [15:0]                         mask_end,
  output logic [outputWidth-1:0]              data_o,
  output logic [addrWidth-1:0]                addr_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic                                last_o,
  output logic                                done_o,
  output logic                                busy_o
);

  localparam int EPW = outputWidth / elementWidth;
  // One bit wider than the mask inputs so ptr+EPW can never wrap.
  localparam int PW  = 17;
  localparam logic [PW-1:0] NUM_EL = PW'(numElements);
  localparam logic [PW-1:0] EPW_P  = PW'(EPW);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FIN
  } state_t;

  state_t                              state_q, state_d;
  logic [numElements*elementWidth-1:0] vec_q, vec_d;
  logic [PW-1:0]                       ptr_q, ptr_d;
  logic [PW-1:0]                       end_q, end_d;
  logic [outputWidth-1:0]              word_q, word_d;
  logic [addrWidth-1:0]                addr_q, addr_d;
  logic                                last_q, last_d;
  logic [PW-1:0]                       elem_idx;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    ptr_d   = ptr_q;
    end_d   = end_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (load_i) begin
          vec_d = data_i;
          ptr_d = {1'b0, mask_start};
          end_d = ({1'b0, mask_end} > NUM_EL) ? NUM_EL : {1'b0, mask_end};
          state_d = (end_d <= ptr_d) ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (ready_i) begin
          if (last_q) state_d = FIN;
          else        ptr_d = ptr_q + EPW_P;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The next word is built from next-state values so every output is a flop.
  always_comb begin
    word_d   = '0;
    elem_idx = '0;
    for (int j = 0; j < EPW; j++) begin
      elem_idx = ptr_d + PW'(j);
      if (elem_idx < end_d)
        word_d[(EPW-1-j)*elementWidth +: elementWidth] =
          vec_d[elem_idx*elementWidth +: elementWidth];
    end
    addr_d = ptr_d[addrWidth-1:0];
    last_d = (state_d == STREAM) && ((ptr_d + EPW_P) >= end_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      ptr_q   <= '0;
      end_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      ptr_q   <= ptr_d;
      end_q   <= end_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  end

  assign data_o       = word_q;
  assign addr_o       = addr_q;
  assign last_o       = last_q;
  assign valid_o      = (state_q == STREAM);
  assign busy_o       = (state_q == STREAM);
  assign done_o       = (state_q == FIN);
  assign load_ready_o = (state_q != STREAM);

endmodule
